// File: rtl/line_mem_server.sv
// Main-memory back-end: serves whole-line reads/writes after a fixed latency.
// Unwritten lines read as a repeated line base address; out-of-range requests flag mem_err.
module line_mem_server #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 512,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] main_mem_addr,
  input  logic              main_mem_read_req,
  input  logic              main_mem_write_req,
  input  logic [LINE_W-1:0] main_mem_data_out,
  output logic [LINE_W-1:0] main_mem_data_in,
  output logic              main_mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int WORDS = LINE_W / 32;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wr_q;
  logic [LINE_W-1:0]      wdata_q;
  logic [LINE_W-1:0]      rdata_q;
  logic                   ready_q;
  logic                   err_q;
  logic [DEPTH_LINES-1:0] written_q;
  logic [LINE_W-1:0]      mem_q [DEPTH_LINES];

  logic [ADDR_W-1:0] base_addr;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [31:0]       base_word;
  logic [LINE_W-1:0] fill;
  logic              commit;

  always_comb begin
    base_addr          = addr_q;
    base_addr[OFF-1:0] = '0;
    idx                = base_addr[OFF+IDX_W-1:OFF];
    in_range           = (addr_q >> (OFF + IDX_W)) == '0;
    base_word          = 32'(base_addr);
    fill               = {WORDS{base_word}};
    commit             = (state_q == BUSY) && (cnt_q == '0);
  end

  // Storage is not reset; a write only lands on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (rst_n && commit && wr_q && in_range) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      written_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (main_mem_read_req || main_mem_write_req) begin
            addr_q  <= main_mem_addr;
            wr_q    <= !main_mem_read_req;
            wdata_q <= main_mem_data_out;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= !in_range;
            if (!wr_q) begin
              if (!in_range)            rdata_q <= '0;
              else if (written_q[idx])  rdata_q <= mem_q[idx];
              else                      rdata_q <= fill;
            end else if (in_range) begin
              written_q[idx] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign main_mem_data_in = rdata_q;
  assign main_mem_ready   = ready_q;
  assign mem_err          = err_q;
  assign mem_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_line_mem_server.sv
// Directed bench for line_mem_server: one instance at LATENCY=4, one at LATENCY=1.
module tb_line_mem_server;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr_a, addr_b;
  logic         rd_a, wr_a, rd_b, wr_b;
  logic [511:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic         ready_a, busy_a, err_a, ready_b, busy_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_mem_server #(.ADDR_W(32), .LINE_W(512), .DEPTH_LINES(1024), .LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .main_mem_addr(addr_a),
    .main_mem_read_req(rd_a), .main_mem_write_req(wr_a),
    .main_mem_data_out(wdata_a), .main_mem_data_in(rdata_a),
    .main_mem_ready(ready_a), .mem_busy(busy_a), .mem_err(err_a)
  );

  line_mem_server #(.ADDR_W(32), .LINE_W(512), .DEPTH_LINES(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .main_mem_addr(addr_b),
    .main_mem_read_req(rd_b), .main_mem_write_req(wr_b),
    .main_mem_data_out(wdata_b), .main_mem_data_in(rdata_b),
    .main_mem_ready(ready_b), .mem_busy(busy_b), .mem_err(err_b)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until ready is seen; n = samples taken (bounded).
  task automatic wait_a(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready_a && n < 40);
  endtask

  // Presents a request for one accept edge, then scrambles addr/data to show they are captured.
  task automatic txn_a(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [511:0] wd, output int n);
    rd_a = rd; wr_a = wr; addr_a = a; wdata_a = wd;
    step();
    rd_a = 1'b0; wr_a = 1'b0; addr_a = ~a; wdata_a = ~wd;
    check("busy_after_accept", 512'(busy_a), 512'(1'b1));
    wait_a(n);
  endtask

  task automatic after_resp(input string tag);
    step();
    check({tag, "_ready_one_cycle"}, 512'(ready_a), 512'(1'b0));
    check({tag, "_busy_clear"}, 512'(busy_a), 512'(1'b0));
  endtask

  initial begin
    int n, seen, t, t1, t2;
    rst_n = 1'b0;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) step();
    check("rst_ready", 512'(ready_a), 512'(1'b0));
    check("rst_err", 512'(err_a), 512'(1'b0));
    check("rst_busy", 512'(busy_a), 512'(1'b0));
    check("rst_data", rdata_a, '0);
    rst_n = 1'b1;
    step();

    // Unwritten line returns its base address pattern
    txn_a(1'b1, 1'b0, 32'h0000_2040, '0, n);
    check("rd_fill_latency", 512'(n), 512'(4));
    check("rd_fill_data", rdata_a, pat(32'h0000_2040));
    check("rd_fill_err", 512'(err_a), 512'(1'b0));
    after_resp("rd_fill");

    txn_a(1'b0, 1'b1, 32'h0000_2000, pat(32'hDEAD_BEEF), n);
    check("wr_latency", 512'(n), 512'(4));
    check("wr_err", 512'(err_a), 512'(1'b0));
    check("wr_keeps_data_in", rdata_a, pat(32'h0000_2040));
    after_resp("wr");

    txn_a(1'b1, 1'b0, 32'h0000_203C, '0, n);
    check("rd_written", rdata_a, pat(32'hDEAD_BEEF));
    after_resp("rd_written");

    // Out of range: line number 0x4000 >= 1024
    txn_a(1'b1, 1'b0, 32'h0010_0000, '0, n);
    check("oor_rd_latency", 512'(n), 512'(4));
    check("oor_rd_err", 512'(err_a), 512'(1'b1));
    check("oor_rd_data", rdata_a, '0);
    after_resp("oor_rd");
    check("oor_err_one_cycle", 512'(err_a), 512'(1'b0));

    txn_a(1'b0, 1'b1, 32'h0010_0000, pat(32'h5555_5555), n);
    check("oor_wr_err", 512'(err_a), 512'(1'b1));
    after_resp("oor_wr");
    txn_a(1'b0, 1'b1, 32'h0010_0040, pat(32'h6666_6666), n);
    check("oor_wr2_err", 512'(err_a), 512'(1'b1));
    after_resp("oor_wr2");
    txn_a(1'b1, 1'b0, 32'h0000_0000, '0, n);
    check("oor_alias_line0", rdata_a, '0);
    after_resp("alias0");
    txn_a(1'b1, 1'b0, 32'h0000_0040, '0, n);
    check("oor_alias_line1", rdata_a, pat(32'h0000_0040));
    after_resp("alias1");
    txn_a(1'b1, 1'b0, 32'h0000_2000, '0, n);
    check("oor_keeps_2000", rdata_a, pat(32'hDEAD_BEEF));
    after_resp("keep");

    // Simultaneous requests: read first, held write follows after RESP->IDLE
    rd_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_3000; wdata_a = pat(32'hCAFE_F00D);
    step();
    wait_a(n);
    check("both_read_latency", 512'(n), 512'(4));
    check("both_read_data", rdata_a, pat(32'h0000_3000));
    rd_a = 1'b0;
    wait_a(n);
    wr_a = 1'b0;
    check("both_write_latency", 512'(n), 512'(6));
    check("both_write_keeps_data", rdata_a, pat(32'h0000_3000));
    after_resp("both");
    txn_a(1'b1, 1'b0, 32'h0000_3000, '0, n);
    check("both_write_committed", rdata_a, pat(32'hCAFE_F00D));
    after_resp("both_rd");

    // Reset while counter = 1 aborts the write with no ready
    wr_a = 1'b1; addr_a = 32'h0000_0040; wdata_a = pat(32'h1111_1111);
    step();
    wr_a = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    seen = 0;
    repeat (4) begin
      step();
      if (ready_a) seen = 1;
    end
    check("abort_no_ready", 512'(seen), 512'(0));
    check("abort_busy", 512'(busy_a), 512'(1'b0));
    rst_n = 1'b1;
    step();
    txn_a(1'b1, 1'b0, 32'h0000_0040, '0, n);
    check("abort_rd_latency", 512'(n), 512'(4));
    check("abort_rd_fill", rdata_a, pat(32'h0000_0040));
    after_resp("abort_rd");

    // LATENCY=1 back-to-back reads with request held
    rd_b = 1'b1; addr_b = 32'h0000_0080;
    t = 0; t1 = -1; t2 = -1;
    while (t < 20 && t2 < 0) begin
      step();
      t++;
      if (ready_b) begin
        if (t1 < 0) begin
          t1 = t;
          check("l1_first_data", rdata_b, pat(32'h0000_0080));
          addr_b = 32'h0000_00C0;
        end else begin
          t2 = t;
          check("l1_second_data", rdata_b, pat(32'h0000_00C0));
        end
      end
    end
    rd_b = 1'b0;
    check("l1_first_latency", 512'(t1), 512'(2));
    check("l1_gap", 512'(t2 - t1), 512'(3));
    check("l1_err", 512'(err_b), 512'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
